// File: rtl/dl_slot_info_pkg.sv
// Shared constants, FSM state type and LDPC-per-gear lookup for the DL slot info writer.
package dl_slot_info_pkg;

  localparam logic [7:0] GEAR_MAX = 8'd7;

  localparam logic [7:0] LDPC_PER_GEAR [0:7] = '{
    8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd12, 8'd16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [7:0] ldpc_limit(input logic [7:0] gear);
    return LDPC_PER_GEAR[gear[2:0]];
  endfunction

endpackage

// File: rtl/dl_slot_info_gen_timer.sv
// Slot sample counter: counts while running, wraps at SLOT_LEN-1; optional external
// slot sync (DL_SLOT_INFO_SYNC_EN) ends the slot early.
module dl_slot_timer #(
  parameter int unsigned SLOT_LEN = 163840,
  parameter int unsigned CNT_W    = 18
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
`ifdef DL_SLOT_INFO_SYNC_EN
  input  logic sync_i,
`endif
  output logic slot_end_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = run_i && (cnt_q == LAST);

  // A sync coincident with the natural wrap still yields a single slot end.
`ifdef DL_SLOT_INFO_SYNC_EN
  assign slot_end_o = wrap || (run_i && sync_i);
`else
  assign slot_end_o = wrap;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = slot_end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dl_slot_info_gen.sv
// Per-slot DL info writer (163.84 MHz side): gear, slot index, LDPC count.
// Optional macro DL_SLOT_INFO_SYNC_EN adds i_slot_sync for forced slot boundaries.
module dl_slot_info_gen
  import dl_slot_info_pkg::*;
#(
  parameter int unsigned SLOT_LEN  = 163840,
  parameter int unsigned NUM_SLOTS = 20,
  parameter int unsigned CNT_W     = 18
) (
  input  logic       clk163m84,
  input  logic       rst_n_163m84,
  input  logic       i_en,
  input  logic [7:0] i_gear_cfg,
  input  logic       i_gear_cfg_vld,
  output logic       o_gear_cfg_rdy,
  input  logic       i_ldpc_done,
`ifdef DL_SLOT_INFO_SYNC_EN
  input  logic       i_slot_sync,
`endif
  output logic [7:0] o_DL_GearEverySlot,
  output logic [7:0] o_slottimesw_cnt,
  output logic [7:0] o_ldpc_cnt,
  output logic       o_slot_start,
  output logic       o_gear_chg,
  output logic       o_ldpc_ovf,
  output logic       o_cfg_err
);

  localparam logic [7:0] LAST_SLOT = 8'(NUM_SLOTS - 1);

  state_e     state_q;
  logic [7:0] gear_q, pend_q, slot_idx_q, ldpc_cnt_q;
  logic       pend_vld_q, rdy_q;
  logic       slot_start_q, gear_chg_q, ldpc_ovf_q, cfg_err_q;

  logic       slot_end, boundary, xfer;
  logic [7:0] next_idx;

  dl_slot_timer #(
    .SLOT_LEN (SLOT_LEN),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk_i      (clk163m84),
    .rst_ni     (rst_n_163m84),
    .run_i      (state_q != IDLE),
    .clr_i      (state_q == IDLE),
`ifdef DL_SLOT_INFO_SYNC_EN
    .sync_i     (i_slot_sync),
`endif
    .slot_end_o (slot_end)
  );

  assign xfer     = i_gear_cfg_vld && rdy_q;
  assign next_idx = (slot_idx_q == LAST_SLOT) ? '0 : slot_idx_q + 8'd1;

  // A slot end only opens a new slot unless a drain is completing.
  always_comb begin
    boundary = 1'b0;
    if (state_q == IDLE) begin
      boundary = i_en;
    end else if (slot_end) begin
      boundary = !((state_q == DRAIN) && !i_en);
    end
  end

  always_ff @(posedge clk163m84 or negedge rst_n_163m84) begin
    if (!rst_n_163m84) begin
      state_q      <= IDLE;
      gear_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      rdy_q        <= 1'b1;
      slot_idx_q   <= '0;
      ldpc_cnt_q   <= '0;
      slot_start_q <= 1'b0;
      gear_chg_q   <= 1'b0;
      ldpc_ovf_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      slot_start_q <= 1'b0;
      gear_chg_q   <= 1'b0;
      ldpc_ovf_q   <= 1'b0;
      cfg_err_q    <= 1'b0;

      // rdy_q low implies a pending gear, so a new transfer never races the apply below.
      if (xfer) begin
        if (i_gear_cfg <= GEAR_MAX) begin
          pend_q     <= i_gear_cfg;
          pend_vld_q <= 1'b1;
          rdy_q      <= 1'b0;
        end else begin
          cfg_err_q  <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE:    if (i_en) state_q <= RUN;
        RUN:     if (!i_en) state_q <= DRAIN;
        DRAIN: begin
          if (i_en)          state_q <= RUN;
          else if (slot_end) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (boundary) begin
        slot_start_q <= 1'b1;
        slot_idx_q   <= (state_q == IDLE) ? '0 : next_idx;
        ldpc_cnt_q   <= '0;
        if (pend_vld_q) begin
          gear_q     <= pend_q;
          gear_chg_q <= (pend_q != gear_q);
          pend_vld_q <= 1'b0;
          rdy_q      <= 1'b1;
        end
      end else if (slot_end) begin
        slot_idx_q <= '0;
        ldpc_cnt_q <= '0;
      end else if ((state_q != IDLE) && i_ldpc_done) begin
        if (ldpc_cnt_q < ldpc_limit(gear_q)) begin
          ldpc_cnt_q <= ldpc_cnt_q + 8'd1;
        end else begin
          ldpc_ovf_q <= 1'b1;
        end
      end
    end
  end

  assign o_gear_cfg_rdy     = rdy_q;
  assign o_DL_GearEverySlot = gear_q;
  assign o_slottimesw_cnt   = slot_idx_q;
  assign o_ldpc_cnt         = ldpc_cnt_q;
  assign o_slot_start       = slot_start_q;
  assign o_gear_chg         = gear_chg_q;
  assign o_ldpc_ovf         = ldpc_ovf_q;
  assign o_cfg_err          = cfg_err_q;

endmodule
